// File: rtl/gold_pkg.sv
// Shared constants and state encoding for the gold bag fall scheduler.
package gold_pkg;

  localparam int unsigned BAG_COORD_W     = 11;
  localparam int unsigned MAP_ADDR_W      = 5;
  localparam int unsigned GOLD_CELL_SHIFT = 5;
  localparam int unsigned GOLD_GRID_COLS  = 20;
  localparam int unsigned GOLD_GRID_ROWS  = 15;

  typedef logic [2:0] sched_state_t;

  localparam sched_state_t S_IDLE   = 3'd0;
  localparam sched_state_t S_SETUP  = 3'd1;
  localparam sched_state_t S_REQ    = 3'd2;
  localparam sched_state_t S_NEXT   = 3'd3;
  localparam sched_state_t S_COMMIT = 3'd4;

endpackage

// File: rtl/gold_cell_addr.sv
// Classifies one bag position: the terrain cell below it, alignment and range.
module gold_cell_addr
  import gold_pkg::*;
#(
  parameter int unsigned CELL_SHIFT = GOLD_CELL_SHIFT,
  parameter int unsigned GRID_COLS  = GOLD_GRID_COLS,
  parameter int unsigned GRID_ROWS  = GOLD_GRID_ROWS
) (
  input  logic [BAG_COORD_W-1:0] x,
  input  logic [BAG_COORD_W-1:0] y,
  input  logic                   active,
  output logic [MAP_ADDR_W-1:0]  col_c,
  output logic [MAP_ADDR_W-1:0]  row_c,
  output logic                   aligned_c,
  output logic                   in_range_c,
  output logic                   skip_c
);

  // One extra bit on the row so the cell below the bottom row is detectable.
  logic [MAP_ADDR_W:0] row_p1;

  assign col_c      = x[CELL_SHIFT+MAP_ADDR_W-1:CELL_SHIFT];
  assign row_p1     = {1'b0, y[CELL_SHIFT+MAP_ADDR_W-1:CELL_SHIFT]} + (MAP_ADDR_W+1)'(1);
  assign row_c      = row_p1[MAP_ADDR_W-1:0];
  assign skip_c     = !active || x[BAG_COORD_W-1] || y[BAG_COORD_W-1];
  assign aligned_c  = (x[CELL_SHIFT-1:0] == '0) && (y[CELL_SHIFT-1:0] == '0);
  assign in_range_c = (row_p1 < (MAP_ADDR_W+1)'(GRID_ROWS)) && (col_c < MAP_ADDR_W'(GRID_COLS));

endmodule

// File: rtl/gold_fall_scheduler.sv
// Per-frame scan of all gold bags over the shared terrain read port; commits
// the resulting can_fall vector in one cycle so every bag sees one snapshot.
module gold_fall_scheduler
  import gold_pkg::*;
#(
  parameter int unsigned NUM_BAGS    = 8,
  parameter int unsigned GRID_COLS   = GOLD_GRID_COLS,
  parameter int unsigned GRID_ROWS   = GOLD_GRID_ROWS,
  parameter int unsigned CELL_SHIFT  = GOLD_CELL_SHIFT,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic                            clk,
  input  logic                            resetN,
  input  logic                            startOfFrame,
  input  logic [NUM_BAGS-1:0]             bag_active,
  input  logic [NUM_BAGS*BAG_COORD_W-1:0] bag_x,
  input  logic [NUM_BAGS*BAG_COORD_W-1:0] bag_y,
  output logic                            map_req,
  output logic [MAP_ADDR_W-1:0]           map_col,
  output logic [MAP_ADDR_W-1:0]           map_row,
  input  logic                            map_ack,
  input  logic                            map_dug,
  output logic [NUM_BAGS-1:0]             can_fall,
  output logic                            scan_done,
  output logic                            overrun,
  output logic                            ack_timeout
);

  localparam int unsigned IDX_W = (NUM_BAGS > 1) ? $clog2(NUM_BAGS) : 1;
  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_BAGS-1:0]   shadow_q, shadow_d;
  logic                  map_req_d;
  logic [MAP_ADDR_W-1:0] map_col_d, map_row_d;
  logic [NUM_BAGS-1:0]   can_fall_d;
  logic                  scan_done_d, overrun_d, ack_timeout_d;

  logic [BAG_COORD_W-1:0] cur_x, cur_y;
  logic [MAP_ADDR_W-1:0]  cur_col, cur_row;
  logic                   cur_aligned, cur_in_range, cur_skip;

  assign cur_x = bag_x[idx_q*BAG_COORD_W +: BAG_COORD_W];
  assign cur_y = bag_y[idx_q*BAG_COORD_W +: BAG_COORD_W];

  gold_cell_addr #(
    .CELL_SHIFT (CELL_SHIFT),
    .GRID_COLS  (GRID_COLS),
    .GRID_ROWS  (GRID_ROWS)
  ) u_cell_addr (
    .x          (cur_x),
    .y          (cur_y),
    .active     (bag_active[idx_q]),
    .col_c      (cur_col),
    .row_c      (cur_row),
    .aligned_c  (cur_aligned),
    .in_range_c (cur_in_range),
    .skip_c     (cur_skip)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    shadow_d      = shadow_q;
    map_req_d     = map_req;
    map_col_d     = map_col;
    map_row_d     = map_row;
    can_fall_d    = can_fall;
    scan_done_d   = 1'b0;
    ack_timeout_d = ack_timeout;
    overrun_d     = overrun || (startOfFrame && (state_q != S_IDLE));

    case (state_q)
      S_IDLE: begin
        if (startOfFrame) begin
          state_d  = S_SETUP;
          idx_d    = '0;
          shadow_d = can_fall;
        end
      end
      S_SETUP: begin
        state_d = S_NEXT;
        if (cur_skip) begin
          shadow_d[idx_q] = 1'b0;
        end else if (!cur_aligned) begin
          // Mid-cell bags keep last frame's decision until they land on a cell.
          shadow_d[idx_q] = shadow_q[idx_q];
        end else if (!cur_in_range) begin
          shadow_d[idx_q] = 1'b0;
        end else begin
          map_col_d = cur_col;
          map_row_d = cur_row;
          map_req_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (map_ack) begin
          shadow_d[idx_q] = map_dug;
          map_req_d       = 1'b0;
          state_d         = S_NEXT;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          shadow_d[idx_q] = 1'b0;
          ack_timeout_d   = 1'b1;
          map_req_d       = 1'b0;
          state_d         = S_NEXT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_NEXT: begin
        map_req_d = 1'b0;
        if (idx_q == IDX_W'(NUM_BAGS - 1)) begin
          state_d = S_COMMIT;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_SETUP;
        end
      end
      S_COMMIT: begin
        can_fall_d  = shadow_q;
        scan_done_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: begin
        map_req_d = 1'b0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      shadow_q    <= '0;
      map_req     <= 1'b0;
      map_col     <= '0;
      map_row     <= '0;
      can_fall    <= '0;
      scan_done   <= 1'b0;
      overrun     <= 1'b0;
      ack_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      map_req     <= map_req_d;
      map_col     <= map_col_d;
      map_row     <= map_row_d;
      can_fall    <= can_fall_d;
      scan_done   <= scan_done_d;
      overrun     <= overrun_d;
      ack_timeout <= ack_timeout_d;
    end
  end

endmodule

// File: tb/tb_gold_fall_scheduler.sv
// Directed bench for gold_fall_scheduler with a terrain responder and a
// frame-level model of the expected can_fall vector and lookup sequence.
module tb_gold_fall_scheduler;

  localparam int NB = 8;
  localparam int CW = 11;

  logic             clk, resetN, startOfFrame;
  logic [NB-1:0]    bag_active;
  logic [NB*CW-1:0] bag_x, bag_y;
  logic             map_req;
  logic [4:0]       map_col, map_row;
  logic             map_ack, map_dug;
  logic [NB-1:0]    can_fall;
  logic             scan_done, overrun, ack_timeout;

  gold_fall_scheduler #(.NUM_BAGS(NB)) dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .bag_active   (bag_active),
    .bag_x        (bag_x),
    .bag_y        (bag_y),
    .map_req      (map_req),
    .map_col      (map_col),
    .map_row      (map_row),
    .map_ack      (map_ack),
    .map_dug      (map_dug),
    .can_fall     (can_fall),
    .scan_done    (scan_done),
    .overrun      (overrun),
    .ack_timeout  (ack_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            bx [NB];
  int            by [NB];
  logic [NB-1:0] bact;
  int            n_vec, n_err, n_req, n_done, n_exp_req;
  int            exp_len, ack_delay, last_len, req_len, rsp_cnt;
  bit            no_ack, exp_overrun, exp_timeout, prev_req;
  logic [9:0]    exp_q [$];
  logic [9:0]    req_log [$];
  logic [9:0]    exp_req;
  logic [NB-1:0] cf_committed, exp_next;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Terrain: a cell is dug unless (row + 2*col) is a multiple of 3.
  function automatic bit dug_at(input int r, input int c);
    return ((r + 2 * c) % 3) != 0;
  endfunction

  task automatic apply_bags();
    for (int i = 0; i < NB; i++) begin
      bag_x[i*CW +: CW] = CW'(bx[i]);
      bag_y[i*CW +: CW] = CW'(by[i]);
    end
    bag_active = bact;
  endtask

  // Frame model: expected committed vector and ordered list of lookups.
  task automatic model_scan();
    logic [NB-1:0] nxt;
    nxt       = cf_committed;
    n_exp_req = 0;
    for (int i = 0; i < NB; i++) begin
      if (!bact[i] || bx[i] < 0 || by[i] < 0) begin
        nxt[i] = 1'b0;
      end else if ((bx[i] % 32) != 0 || (by[i] % 32) != 0) begin
        nxt[i] = cf_committed[i];
      end else if ((by[i] / 32) + 1 >= 15 || (bx[i] / 32) >= 20) begin
        nxt[i] = 1'b0;
      end else begin
        int c, r;
        c = bx[i] / 32;
        r = by[i] / 32 + 1;
        exp_q.push_back({5'(c), 5'(r)});
        n_exp_req++;
        if (no_ack) begin
          nxt[i]      = 1'b0;
          exp_timeout = 1'b1;
        end else begin
          nxt[i] = dug_at(r, c);
        end
      end
    end
    exp_next = nxt;
    exp_len  = no_ack ? 15 : ack_delay;
  endtask

  task automatic pulse_sof();
    @(posedge clk); #1 startOfFrame = 1'b1;
    @(posedge clk); #1 startOfFrame = 1'b0;
  endtask

  task automatic run_scan(input bit dbl);
    int d0, r0;
    bit got;
    d0 = n_done;
    r0 = n_req;
    apply_bags();
    model_scan();
    pulse_sof();
    if (dbl) begin
      exp_overrun = 1'b1;
      pulse_sof();
    end
    got = 1'b0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk);
      if (n_done != d0) begin
        got = 1'b1;
        break;
      end
    end
    #1;
    chk("scan_done_seen", 32'(got), 32'd1);
    if (dbl) repeat (60) @(posedge clk);
    #1;
    chk("scan_done_count", 32'(n_done - d0), 32'd1);
    chk("request_count", 32'(n_req - r0), 32'(n_exp_req));
    chk("overrun", 32'(overrun), 32'(exp_overrun));
    chk("ack_timeout", 32'(ack_timeout), 32'(exp_timeout));
    chk("lookups_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  // Terrain responder: acks the ack_delay-th cycle of each request.
  initial begin
    map_ack = 1'b0;
    map_dug = 1'b0;
    rsp_cnt = 0;
    forever begin
      @(negedge clk);
      if (resetN && map_req && !no_ack) begin
        rsp_cnt++;
        if (rsp_cnt == ack_delay) begin
          map_ack = 1'b1;
          map_dug = dug_at(int'(map_row), int'(map_col));
        end else begin
          map_ack = 1'b0;
        end
      end else begin
        rsp_cnt = 0;
        map_ack = 1'b0;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (!resetN) begin
      prev_req = 1'b0;
      req_len  = 0;
    end else begin
      if (map_req) begin
        if (!prev_req) begin
          n_req++;
          req_log.push_back({map_col, map_row});
          if (exp_q.size() == 0) begin
            chk("unexpected_request", {22'd0, map_col, map_row}, 32'h3ff);
          end else begin
            exp_req = exp_q.pop_front();
            chk("map_col", 32'(map_col), 32'(exp_req[9:5]));
            chk("map_row", 32'(map_row), 32'(exp_req[4:0]));
          end
        end
        req_len++;
      end else if (prev_req) begin
        last_len = req_len;
        chk("req_length", 32'(req_len), 32'(exp_len));
        req_len = 0;
      end
      prev_req = map_req;
      if (scan_done) begin
        n_done++;
        chk("can_fall_commit", 32'(can_fall), 32'(exp_next));
        cf_committed = exp_next;
      end else begin
        chk("can_fall_hold", 32'(can_fall), 32'(cf_committed));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int r0;
    n_vec = 0; n_err = 0; n_req = 0; n_done = 0; last_len = 0;
    resetN = 1'b0; startOfFrame = 1'b0;
    no_ack = 1'b0; ack_delay = 2;
    exp_overrun = 1'b0; exp_timeout = 1'b0;
    cf_committed = '0; exp_next = '0;
    bact = '0;
    for (int i = 0; i < NB; i++) begin bx[i] = 0; by[i] = 0; end
    apply_bags();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_map_req", 32'(map_req), 32'd0);
    chk("rst_map_col", 32'(map_col), 32'd0);
    chk("rst_map_row", 32'(map_row), 32'd0);
    chk("rst_can_fall", 32'(can_fall), 32'd0);
    chk("rst_scan_done", 32'(scan_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    chk("rst_ack_timeout", 32'(ack_timeout), 32'd0);
    resetN = 1'b1;
    repeat (2) @(posedge clk);

    // Aligned bag over a dug cell.
    bact = 8'h01; bx[0] = 64; by[0] = 160;
    r0 = n_req;
    run_scan(1'b0);
    chk("t1_can_fall", 32'(can_fall), 32'h01);
    chk("t1_col", 32'(req_log[r0][9:5]), 32'd2);
    chk("t1_row", 32'(req_log[r0][4:0]), 32'd6);
    chk("t1_len", 32'(last_len), 32'd2);

    // Mid-cell: no lookup, previous decision held.
    by[0] = 170;
    run_scan(1'b0);
    chk("t2_can_fall", 32'(can_fall), 32'h01);

    // Bottom row: no cell below.
    by[0] = 448;
    run_scan(1'b0);
    chk("t3_can_fall", 32'(can_fall), 32'h00);

    // Inactive bag after a positive result.
    by[0] = 160;
    run_scan(1'b0);
    chk("t4a_can_fall", 32'(can_fall), 32'h01);
    bact = 8'h00;
    run_scan(1'b0);
    chk("t4b_can_fall", 32'(can_fall), 32'h00);

    // Lookup never acknowledged.
    bact = 8'h01; no_ack = 1'b1;
    run_scan(1'b0);
    chk("t5_can_fall", 32'(can_fall), 32'h00);
    chk("t5_len", 32'(last_len), 32'd15);
    chk("t5_ack_timeout", 32'(ack_timeout), 32'd1);
    no_ack = 1'b0;

    // Mixed frame: dug, solid, off-grid, negative, bottom-edge, misaligned.
    ack_delay = 1; bact = 8'hFF;
    bx[0] = 0;   by[0] = 0;
    bx[1] = 32;  by[1] = 32;
    bx[2] = 96;  by[2] = 64;
    bx[3] = 640; by[3] = 0;
    bx[4] = -32; by[4] = 64;
    bx[5] = 128; by[5] = 416;
    bx[6] = 608; by[6] = 0;
    bx[7] = 33;  by[7] = 64;
    run_scan(1'b0);
    chk("t6_can_fall", 32'(can_fall), 32'h23);

    // Positive bags drift mid-cell and keep their bits.
    ack_delay = 5;
    bx[0] = 0; by[0] = 5; bx[1] = 40; bx[5] = 128; by[5] = 420;
    run_scan(1'b0);
    chk("t7_can_fall", 32'(can_fall), 32'h23);

    // Eight lookups with a second startOfFrame mid-scan.
    ack_delay = 2;
    for (int i = 0; i < NB; i++) begin bx[i] = 32 * i; by[i] = 32 * i; end
    run_scan(1'b1);
    chk("t8_can_fall", 32'(can_fall), 32'hFF);
    chk("t8_overrun", 32'(overrun), 32'd1);

    // Asynchronous reset while a lookup is outstanding.
    apply_bags();
    model_scan();
    pulse_sof();
    for (int k = 0; k < 100; k++) begin
      @(posedge clk);
      #1;
      if (map_req) break;
    end
    chk("t9_req_before_reset", 32'(map_req), 32'd1);
    #2;
    cf_committed = '0;
    exp_q.delete();
    resetN = 1'b0;
    #1;
    chk("t9_map_req", 32'(map_req), 32'd0);
    chk("t9_can_fall", 32'(can_fall), 32'd0);
    chk("t9_overrun", 32'(overrun), 32'd0);
    chk("t9_ack_timeout", 32'(ack_timeout), 32'd0);
    exp_overrun = 1'b0; exp_timeout = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;

    // Fresh scan starts at bag 0; misaligned bag inherits the cleared bit.
    bact = 8'h03;
    bx[0] = 32; by[0] = 32; bx[1] = 40; by[1] = 32;
    r0 = n_req;
    run_scan(1'b0);
    chk("t10_can_fall", 32'(can_fall), 32'h01);
    chk("t10_col", 32'(req_log[r0][9:5]), 32'd1);
    chk("t10_row", 32'(req_log[r0][4:0]), 32'd2);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
